// File: rtl/d_ff1.sv
// Parameterisable rising-edge D flip-flop with asynchronous active-low reset.
// The port order Q, D, CLK, n_Reset is fixed because instances connect by position.
module d_ff1 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  input  logic             n_Reset
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // No enable and no synchronous clear, so every rising edge loads D.
  always_comb begin
    q_d = D;
  end

  // NOTE: non-blocking assignment keeps this flop race-free against other flops on CLK.
  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_d_ff1.sv
// Scoreboard bench for d_ff1: a 1-bit default instance and an 8-bit instance
// with a non-zero reset value, both sharing clock and reset.
module tb_d_ff1;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       n_reset;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[$];

  d_ff1 u_dut1 (
    .Q       (q1),
    .D       (d1),
    .CLK     (clk),
    .n_Reset (n_reset)
  );

  d_ff1 #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
    .Q       (q8),
    .D       (d8),
    .CLK     (clk),
    .n_Reset (n_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic rst_n_v, input logic [7:0] dv8, input logic dv1);
    return rst_n_v ? {dv8, dv1} : {RV8, 1'b0};
  endfunction

  // Drive on the falling edge, predict, then compare just after the rising edge.
  // Mid-period the D inputs are inverted to show Q ignores D between edges.
  task automatic do_cycle(input string tag, input logic rst_v, input logic dv1, input logic [7:0] dv8);
    logic [8:0] exp;
    @(negedge clk);
    n_reset = rst_v;
    d1      = dv1;
    d8      = dv8;
    exp_q.push_back(model(rst_v, dv8, dv1));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 9'h0, 9'h1FF);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {q8, q1}, exp);
      #2;
      d1 = ~d1;
      d8 = ~d8;
      #1;
      check({tag, "_hold"}, {q8, q1}, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    n_reset = 1'b0;
    d1      = 1'b0;
    d8      = 8'h00;

    // Reset state after the first rising edge with reset held low.
    @(posedge clk);
    #1;
    check("reset_state", {q8, q1}, {RV8, 1'b0});

    do_cycle("rst_d1", 1'b0, 1'b1, 8'hFF);
    do_cycle("rst_d0", 1'b0, 1'b0, 8'h00);
    do_cycle("rel_d1", 1'b1, 1'b1, 8'h3C);
    do_cycle("run_d0", 1'b1, 1'b0, 8'hC3);
    do_cycle("run_d1", 1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 8; i++) begin
      do_cycle("rand", 1'b1, 1'($urandom_range(1)), 8'($urandom_range(255)));
    end

    // Asynchronous clear mid-period, no clock edge involved.
    do_cycle("pre_async", 1'b1, 1'b1, 8'h0F);
    #1;
    n_reset = 1'b0;
    #1;
    check("async_clear", {q8, q1}, {RV8, 1'b0});

    // Release on the falling edge: Q keeps the reset value until the next rising edge.
    @(negedge clk);
    d1      = 1'b1;
    d8      = 8'h99;
    n_reset = 1'b1;
    #1;
    check("release_hold", {q8, q1}, {RV8, 1'b0});
    @(posedge clk);
    #1;
    check("release_capture", {q8, q1}, {8'h99, 1'b1});

    // Reset asserted in the same time step as a rising edge: reset wins.
    @(negedge clk);
    d1 = 1'b1;
    d8 = 8'h77;
    @(posedge clk);
    n_reset = 1'b0;
    #1;
    check("reset_vs_clock", {q8, q1}, {RV8, 1'b0});

    do_cycle("rst_again", 1'b0, 1'b1, 8'h12);
    do_cycle("rel_again", 1'b1, 1'b1, 8'h34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
